mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 nRST  in  1  reset, synchronous, active-low; sampled only on rising CLK.
REQ-003 ihit  in  1  pipeline advance enable from instruction side.
REQ-004 flush  in  1  insert bubble into MEM/WB on next advance.
REQ-005 dWEN_in, dREN_in, RegWrite_in, Halt_in  in  1 each  EX/MEM control outputs.
REQ-006 MemToReg_in  in  2  writeback select: 0 Porto, 1 load data, 2 pcp4, 3 LUI.
REQ-007 wsel_in  in  regbits_t  destination register.
REQ-008 Porto_in, pcp4_in, dmemstr_in, LUI_in  in  word_t  ALU result, PC+4, store data, LUI value.
REQ-009 dhit  in  1  data cache completes current request this cycle.
REQ-010 dmemload  in  word_t  load data, valid when dhit.
REQ-011 dmemREN, dmemWEN  out  1  data cache request strobes.
REQ-012 dmemaddr, dmemstore  out  word_t  request address (Porto_in) and store data (dmemstr_in).
REQ-013 mem_stall  out  1  freeze all upstream latches this cycle.
REQ-014 RegWrite_wb, Halt_wb  out  1  MEM/WB registered controls.
REQ-015 wsel_wb  out  regbits_t; wdat_wb  out  word_t  registered writeback destination and data.

Function
REQ-016 State machine states IDLE, BUSY, DONE; state register updates only on rising CLK.
REQ-017 req = (dREN_in | dWEN_in) & (state != DONE); dmemREN = req & dREN_in; dmemWEN = req & dWEN_in; both combinational.
REQ-018 dmemREN and dmemWEN never both 1; if both inputs 1, dmemREN wins and dmemWEN = 0.
REQ-019 mem_stall = req & ~dhit; advance = ihit & ~mem_stall.
REQ-020 IDLE: req & ~dhit -> BUSY; req & dhit & ~ihit -> DONE; otherwise stay IDLE.
REQ-021 BUSY: dhit & ihit -> IDLE; dhit & ~ihit -> DONE; ~dhit -> stay BUSY with request held constant.
REQ-022 DONE: ihit -> IDLE; else stay; no request issued in DONE.
REQ-023 On dhit with dREN, dmemload captured into an internal load buffer; MemToReg=1 selects buffer in DONE, dmemload directly otherwise.
REQ-024 wdat mux: 0 Porto_in, 1 load data, 2 pcp4_in, 3 LUI_in; result registered into wdat_wb on advance.
REQ-025 On advance & ~flush: RegWrite_wb, Halt_wb, wsel_wb, wdat_wb load from inputs; latency 1 cycle.
REQ-026 On advance & flush: RegWrite_wb=0, Halt_wb=0, wsel_wb=0, wdat_wb=0 (bubble); a pending memory access is still completed before advance.
REQ-027 No advance: all MEM/WB outputs hold.
REQ-028 Halt_wb sticky: once 1, remains 1 until reset regardless of flush or advance.
REQ-029 Ops with neither dREN_in nor dWEN_in never stall and never leave IDLE.

Reset
REQ-030 nRST=0 at rising CLK: state=IDLE, load buffer=0, RegWrite_wb=0, Halt_wb=0, wsel_wb=0, wdat_wb=0.
REQ-031 Reset mid-access (BUSY/DONE) abandons the request; dmemREN/dmemWEN drop the cycle after reset is sampled and restart only from IDLE.

Structure
REQ-032 word_t, regbits_t, opcode_t and memstate_t (IDLE, BUSY, DONE) live in cpu_types_pkg.
REQ-033 MEM/WB register is one sub-module, mem_wb_reg, driven through a MEM_WB_if interface with mem and wb modports; FSM and wdat mux stay in mem_stage.

Verification
REQ-034 Reset: nRST=0 one cycle with dREN_in=1 -> all _wb outputs 0, dmemREN=0 next cycle.
REQ-035 Load, dhit after 3 cycles, ihit=1 throughout: dREN_in=1, Porto=0x100, dmemload=0xDEADBEEF -> dmemaddr=0x100, mem_stall=1 for 3 cycles, wdat_wb=0xDEADBEEF, RegWrite_wb as given, one cycle after dhit.
REQ-036 Load, dhit while ihit=0, ihit 2 cycles later: dmemload changes to 0x0 after dhit -> state DONE, no re-request, wdat_wb=0xDEADBEEF on advance.
REQ-037 Store with flush=1: dWEN_in=1, dmemstr=0x1234 -> dmemWEN=1 until dhit, dmemstore=0x1234, then bubble (RegWrite_wb=0).
REQ-038 ALU op, MemToReg=2, pcp4=0x44, ihit=1 -> mem_stall=0, wdat_wb=0x44 next cycle; then Halt_in=1 -> Halt_wb=1, held after flush and subsequent ops until nRST=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, opcodes, memory-stage
// FSM states and the writeback source select.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 6;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_LUI   = 6'h0f,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b,
    OP_HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memstate_t;

  typedef enum logic [1:0] {
    WB_PORTO = 2'd0,
    WB_LOAD  = 2'd1,
    WB_PCP4  = 2'd2,
    WB_LUI   = 2'd3
  } wbsel_t;

endpackage

// File: rtl/MEM_WB_if.sv
// MEM/WB pipeline register boundary: the mem side supplies next values and
// the advance/flush controls, the wb side returns the registered outputs.
interface MEM_WB_if;
  import cpu_types_pkg::*;

  logic     advance;
  logic     flush;
  logic     RegWrite;
  logic     Halt;
  regbits_t wsel;
  word_t    wdat;

  logic     RegWrite_wb;
  logic     Halt_wb;
  regbits_t wsel_wb;
  word_t    wdat_wb;

  modport mem (
    output advance, flush, RegWrite, Halt, wsel, wdat,
    input  RegWrite_wb, Halt_wb, wsel_wb, wdat_wb
  );

  modport wb (
    input  advance, flush, RegWrite, Halt, wsel, wdat,
    output RegWrite_wb, Halt_wb, wsel_wb, wdat_wb
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on advance, inserts a bubble on flush,
// holds otherwise; Halt is sticky until reset.
module mem_wb_reg
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  MEM_WB_if.wb wb_if
);

  logic     regwrite_q, regwrite_d;
  logic     halt_q, halt_d;
  regbits_t wsel_q, wsel_d;
  word_t    wdat_q, wdat_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    regwrite_d = regwrite_q;
    wsel_d     = wsel_q;
    wdat_d     = wdat_q;
    if (wb_if.advance) begin
      if (wb_if.flush) begin
        regwrite_d = 1'b0;
        wsel_d     = '0;
        wdat_d     = '0;
      end else begin
        regwrite_d = wb_if.RegWrite;
        wsel_d     = wb_if.wsel;
        wdat_d     = wb_if.wdat;
      end
    end
    // A bubble clears Halt only if it was never set.
    halt_d = halt_q | (wb_if.advance & ~wb_if.flush & wb_if.Halt);
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nRST) begin
      regwrite_q <= 1'b0;
      halt_q     <= 1'b0;
      wsel_q     <= '0;
      wdat_q     <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      halt_q     <= halt_d;
      wsel_q     <= wsel_d;
      wdat_q     <= wdat_d;
    end
  end

  assign wb_if.RegWrite_wb = regwrite_q;
  assign wb_if.Halt_wb     = halt_q;
  assign wb_if.wsel_wb     = wsel_q;
  assign wb_if.wdat_wb     = wdat_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-cache request FSM, load buffer, writeback data
// select and the MEM/WB register.
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     flush,
  input  logic     dWEN_in,
  input  logic     dREN_in,
  input  logic     RegWrite_in,
  input  logic     Halt_in,
  input  logic [1:0] MemToReg_in,
  input  regbits_t wsel_in,
  input  word_t    Porto_in,
  input  word_t    pcp4_in,
  input  word_t    dmemstr_in,
  input  word_t    LUI_in,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output logic     mem_stall,
  output logic     RegWrite_wb,
  output logic     Halt_wb,
  output regbits_t wsel_wb,
  output word_t    wdat_wb
);

  memstate_t state_q, state_d;
  word_t     ldbuf_q, ldbuf_d;
  logic      req;
  logic      advance;
  word_t     wdat;

  // No request is presented while reset is held, so an abandoned access
  // only restarts once the FSM is back in IDLE.
  assign req       = (dREN_in | dWEN_in) & (state_q != DONE) & nRST;
  assign dmemREN   = req & dREN_in;
  assign dmemWEN   = req & dWEN_in & ~dREN_in;
  assign dmemaddr  = Porto_in;
  assign dmemstore = dmemstr_in;
  assign mem_stall = req & ~dhit;
  assign advance   = ihit & ~mem_stall;

  always_comb begin
    state_d = state_q;
    ldbuf_d = ldbuf_q;
    if (req && dhit && dREN_in) ldbuf_d = dmemload;
    unique case (state_q)
      IDLE: begin
        if (req && !dhit)            state_d = BUSY;
        else if (req && dhit && !ihit) state_d = DONE;
      end
      BUSY:    if (dhit) state_d = ihit ? IDLE : DONE;
      DONE:    if (ihit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      ldbuf_q <= '0;
    end else begin
      state_q <= state_d;
      ldbuf_q <= ldbuf_d;
    end
  end

  // In DONE the cache has already released dmemload, so use the buffered copy.
  always_comb begin
    wdat = Porto_in;
    case (wbsel_t'(MemToReg_in))
      WB_PORTO: wdat = Porto_in;
      WB_LOAD:  wdat = (state_q == DONE) ? ldbuf_q : dmemload;
      WB_PCP4:  wdat = pcp4_in;
      WB_LUI:   wdat = LUI_in;
      default:  wdat = Porto_in;
    endcase
  end

  MEM_WB_if mem_wb ();

  assign mem_wb.advance  = advance;
  assign mem_wb.flush    = flush;
  assign mem_wb.RegWrite = RegWrite_in;
  assign mem_wb.Halt     = Halt_in;
  assign mem_wb.wsel     = wsel_in;
  assign mem_wb.wdat     = wdat;

  mem_wb_reg u_mem_wb_reg (
    .CLK   (CLK),
    .nRST  (nRST),
    .wb_if (mem_wb.wb)
  );

  assign RegWrite_wb = mem_wb.RegWrite_wb;
  assign Halt_wb     = mem_wb.Halt_wb;
  assign wsel_wb     = mem_wb.wsel_wb;
  assign wdat_wb     = mem_wb.wdat_wb;

endmodule
